// File: rtl/riscv_defs.sv
// Shared RV32I decode definitions: opcodes, funct3 codes and immediate extraction.
package riscv_defs;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Integer register file: 2 combinational reads, 1 synchronous write, x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_dest,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en && (wb_dest != 5'd0)) begin
      r_regs[wb_dest] <= wb_data;
    end
  end

  always_comb begin
    w_rs1 = (rs1_addr == 5'd0) ? '0 : r_regs[rs1_addr];
    w_rs2 = (rs2_addr == 5'd0) ? '0 : r_regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_en && (wb_dest != 5'd0) && (wb_dest == rs1_addr)) w_rs1 = wb_data;
    if (wb_en && (wb_dest != 5'd0) && (wb_dest == rs2_addr)) w_rs2 = wb_data;
`endif
  end

  assign rs1_data = w_rs1;
  assign rs2_data = w_rs2;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: valid/ready capture of an instruction, register read, registered class bundle.
// Build option REGFILE_BYPASS_EN forwards a same-cycle writeback into the operand reads.
module decode_stage
  import riscv_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] instr_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_dest,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            is_store,
  output logic            is_load,
  output logic            is_branch,
  output logic            is_jump,
  output logic            is_reg,
  output logic            is_alu,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] branch_dest,
  output logic [4:0]      dest,
  output logic [2:0]      func3,
  output logic            func7,
  output logic [XLEN-1:0] curr_pc,
  output logic            illegal
);

  logic [XLEN-1:0] w_rs1, w_rs2;
  logic [XLEN-1:0] w_a, w_b, w_bd;
  logic [4:0]      w_dest;
  logic [2:0]      w_f3;
  logic            w_f7, w_ill;
  logic            w_store, w_load, w_branch, w_jump, w_reg, w_alu;
  logic            w_fire;

  logic            r_valid;
  logic            r_store, r_load, r_branch, r_jump, r_reg, r_alu, r_ill;
  logic [XLEN-1:0] r_a, r_b, r_sd, r_bd, r_pc;
  logic [4:0]      r_dest;
  logic [2:0]      r_f3;
  logic            r_f7;

  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (instr[19:15]),
    .rs2_addr (instr[24:20]),
    .rs1_data (w_rs1),
    .rs2_data (w_rs2),
    .wb_en    (wb_en),
    .wb_dest  (wb_dest),
    .wb_data  (wb_data)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_fire   = in_valid && in_ready;

  always_comb begin
    w_store  = 1'b0;
    w_load   = 1'b0;
    w_branch = 1'b0;
    w_jump   = 1'b0;
    w_reg    = 1'b0;
    w_alu    = 1'b0;
    w_ill    = 1'b0;
    w_a      = '0;
    w_b      = '0;
    w_bd     = '0;
    w_dest   = instr[11:7];
    w_f3     = instr[14:12];
    w_f7     = 1'b0;
    case (instr[6:0])
      OP: begin
        w_alu = 1'b1; w_a = w_rs1; w_b = w_rs2; w_f7 = instr[30];
      end
      OP_IMM: begin
        // Only shifts carry the arithmetic/logical qualifier; elsewhere bit 30 is immediate data.
        w_alu = 1'b1; w_a = w_rs1; w_b = imm_i(instr);
        w_f7  = (instr[14:12] == F3_SR) ? instr[30] : 1'b0;
      end
      LUI: begin
        w_alu = 1'b1; w_f3 = F3_ADD; w_b = imm_u(instr);
      end
      AUIPC: begin
        w_alu = 1'b1; w_f3 = F3_ADD; w_a = instr_pc; w_b = imm_u(instr);
      end
      BRANCH: begin
        w_branch = 1'b1; w_a = w_rs1; w_b = w_rs2; w_bd = imm_b(instr); w_dest = 5'd0;
      end
      JAL: begin
        w_jump = 1'b1; w_a = imm_j(instr);
      end
      JALR: begin
        w_jump = 1'b1; w_reg = 1'b1; w_a = w_rs1; w_b = imm_i(instr);
      end
      LOAD: begin
        w_load = 1'b1; w_a = w_rs1; w_b = imm_i(instr);
      end
      STORE: begin
        w_store = 1'b1; w_a = w_rs1; w_b = imm_s(instr); w_dest = 5'd0;
      end
      default: begin
        w_ill = 1'b1; w_dest = 5'd0;
      end
    endcase
  end

  // Output register: flush beats capture; a stalled bundle holds every field.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_store  <= 1'b0;
      r_load   <= 1'b0;
      r_branch <= 1'b0;
      r_jump   <= 1'b0;
      r_reg    <= 1'b0;
      r_alu    <= 1'b0;
      r_ill    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sd     <= '0;
      r_bd     <= '0;
      r_pc     <= '0;
      r_dest   <= '0;
      r_f3     <= '0;
      r_f7     <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_valid  <= 1'b1;
      r_store  <= w_store;
      r_load   <= w_load;
      r_branch <= w_branch;
      r_jump   <= w_jump;
      r_reg    <= w_reg;
      r_alu    <= w_alu;
      r_ill    <= w_ill;
      r_a      <= w_a;
      r_b      <= w_b;
      r_sd     <= w_rs2;
      r_bd     <= w_bd;
      r_pc     <= instr_pc;
      r_dest   <= w_dest;
      r_f3     <= w_f3;
      r_f7     <= w_f7;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign is_store    = r_store;
  assign is_load     = r_load;
  assign is_branch   = r_branch;
  assign is_jump     = r_jump;
  assign is_reg      = r_reg;
  assign is_alu      = r_alu;
  assign illegal     = r_ill;
  assign operand_a   = r_a;
  assign operand_b   = r_b;
  assign store_data  = r_sd;
  assign branch_dest = r_bd;
  assign curr_pc     = r_pc;
  assign dest        = r_dest;
  assign func3       = r_f3;
  assign func7       = r_f7;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against a behavioural decode/handshake model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
  logic [31:0] instr, instr_pc, wb_data;
  logic [4:0]  wb_dest;
  logic        is_store, is_load, is_branch, is_jump, is_reg, is_alu, func7, illegal;
  logic [31:0] operand_a, operand_b, store_data, branch_dest, curr_pc;
  logic [4:0]  dest;
  logic [2:0]  func3;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .instr_pc(instr_pc), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .is_store(is_store), .is_load(is_load), .is_branch(is_branch), .is_jump(is_jump),
    .is_reg(is_reg), .is_alu(is_alu), .operand_a(operand_a), .operand_b(operand_b),
    .store_data(store_data), .branch_dest(branch_dest), .dest(dest), .func3(func3),
    .func7(func7), .curr_pc(curr_pc), .illegal(illegal)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_rf [32];
  logic        m_valid, m_ill, m_f7;
  logic [5:0]  m_flags;  // {store, load, branch, jump, reg, alu}
  logic [31:0] m_a, m_b, m_sd, m_bd, m_pc;
  logic [4:0]  m_dest;
  logic [2:0]  m_f3;

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    int s;
    s = int'(v << (32 - bits));
    return 32'(s >>> (32 - bits));
  endfunction

  function automatic logic [31:0] rd(input int idx);
    if (idx == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wb_en && wb_dest != 0 && int'(wb_dest) == idx) return wb_data;
`endif
    return m_rf[idx];
  endfunction

  task automatic model_capture(input logic [31:0] ins, input logic [31:0] pc);
    logic [31:0] r1, r2, i_imm, s_imm, b_imm, u_imm, j_imm;
    int op;
    op    = int'(ins & 32'h7f);
    r1    = rd(int'((ins >> 15) & 31));
    r2    = rd(int'((ins >> 20) & 31));
    i_imm = sx(ins >> 20, 12);
    s_imm = sx(((ins >> 25) << 5) | ((ins >> 7) & 31), 12);
    b_imm = sx((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
               (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
    u_imm = ins & 32'hFFFFF000;
    j_imm = sx((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
               (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
    m_flags = 6'b0; m_ill = 1'b0; m_a = 0; m_b = 0; m_bd = 0; m_f7 = 1'b0;
    m_dest = 5'((ins >> 7) & 31); m_f3 = 3'((ins >> 12) & 7); m_sd = r2; m_pc = pc;
    case (op)
      'h33: begin m_flags = 6'b000001; m_a = r1; m_b = r2; m_f7 = ins[30]; end
      'h13: begin m_flags = 6'b000001; m_a = r1; m_b = i_imm; m_f7 = (m_f3 == 5) ? ins[30] : 1'b0; end
      'h37: begin m_flags = 6'b000001; m_f3 = 0; m_b = u_imm; end
      'h17: begin m_flags = 6'b000001; m_f3 = 0; m_a = pc; m_b = u_imm; end
      'h63: begin m_flags = 6'b001000; m_a = r1; m_b = r2; m_bd = b_imm; m_dest = 0; end
      'h6F: begin m_flags = 6'b000100; m_a = j_imm; end
      'h67: begin m_flags = 6'b000110; m_a = r1; m_b = i_imm; end
      'h03: begin m_flags = 6'b010000; m_a = r1; m_b = i_imm; end
      'h23: begin m_flags = 6'b100000; m_a = r1; m_b = s_imm; m_dest = 0; end
      default: begin m_ill = 1'b1; m_dest = 0; end
    endcase
  endtask

  task automatic model_edge();
    logic acc;
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      m_valid = 0; m_flags = 0; m_ill = 0; m_a = 0; m_b = 0; m_sd = 0;
      m_bd = 0; m_pc = 0; m_dest = 0; m_f3 = 0; m_f7 = 0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      if (flush) m_valid = 0;
      else if (acc) begin model_capture(instr, instr_pc); m_valid = 1; end
      else if (out_ready) m_valid = 0;
      if (wb_en && wb_dest != 0) m_rf[wb_dest] = wb_data;
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("flags", 32'({is_store, is_load, is_branch, is_jump, is_reg, is_alu}), 32'(m_flags));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("operand_a", operand_a, m_a);
    chk("operand_b", operand_b, m_b);
    chk("store_data", store_data, m_sd);
    chk("branch_dest", branch_dest, m_bd);
    chk("curr_pc", curr_pc, m_pc);
    chk("dest", 32'(dest), 32'(m_dest));
    chk("func3", 32'(func3), 32'(m_f3));
    chk("func7", 32'(func7), 32'(m_f7));
  endtask

  task automatic cycle();
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; instr = ins; instr_pc = pc; out_ready = 1'b1;
  endtask

  logic [6:0]  opcs [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h7F};
  logic [31:0] exp_a;

  initial begin
    reset = 1'b0; in_valid = 0; instr = 0; instr_pc = 0; wb_en = 0; wb_dest = 0;
    wb_data = 0; flush = 0; out_ready = 1'b1;
    cycle(); cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_operand_a", operand_a, 32'd0);
    reset = 1'b1;

    // addi x6,x5,-1 after x5 = 0x10
    wb_en = 1; wb_dest = 5; wb_data = 32'h10; cycle();
    wb_en = 0; send(32'hFFF28313, 32'h100); cycle();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_alu", 32'(is_alu), 32'd1);
    chk("t1_a", operand_a, 32'h10);
    chk("t1_b", operand_b, 32'hFFFFFFFF);
    chk("t1_f3f7", 32'({func3, func7}), 32'd0);
    chk("t1_dest", 32'(dest), 32'd6);

    // srai x7,x5,3
    send(32'h4032D393, 32'h104); cycle();
    chk("t2_f3", 32'(func3), 32'd5);
    chk("t2_f7", 32'(func7), 32'd1);
    chk("t2_b", operand_b, 32'h403);
    chk("t2_dest", 32'(dest), 32'd7);

    // jal x0,8 then stall
    send(32'h0080006F, 32'h108); cycle();
    chk("t3_jump", 32'({is_jump, is_reg}), 32'b10);
    chk("t3_a", operand_a, 32'd8);
    chk("t3_dest", 32'(dest), 32'd0);
    send(32'hFFF28313, 32'h10C); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold_ready", 32'(in_ready), 32'd0);
      chk("t3_hold_a", operand_a, 32'd8);
      chk("t3_hold_pc", curr_pc, 32'h108);
    end
    out_ready = 1'b1; cycle();
    chk("t3_release_dest", 32'(dest), 32'd6);
    chk("t3_release_pc", curr_pc, 32'h10C);

    // writeback in the capture cycle, then write to x0
    send(32'hFFF28313, 32'h110); wb_en = 1; wb_dest = 5; wb_data = 32'h20; cycle();
`ifdef REGFILE_BYPASS_EN
    exp_a = 32'h20;
`else
    exp_a = 32'h10;
`endif
    chk("t4_bypass_a", operand_a, exp_a);
    in_valid = 0; wb_dest = 0; wb_data = 32'hDEADBEEF; cycle();
    wb_en = 0; send(32'h00500093, 32'h114); cycle();
    chk("t4_x0_a", operand_a, 32'd0);
    chk("t4_x0_b", operand_b, 32'd5);

    // illegal opcode, then flush with a competing instruction
    send(32'hFFFFFFFF, 32'h118); cycle();
    chk("t5_illegal", 32'(illegal), 32'd1);
    chk("t5_flags", 32'({is_store, is_load, is_branch, is_jump, is_reg, is_alu}), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd1);
    send(32'h0080006F, 32'h11C); flush = 1; cycle();
    flush = 0; in_valid = 0;
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    chk("t5_flush_nocap", 32'(is_jump), 32'd0);

    // reset mid-stream
    send(32'hFFF28313, 32'h120); cycle();
    reset = 0; in_valid = 0; cycle();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_b", operand_b, 32'd0);
    reset = 1; send(32'hFFF28313, 32'h124); cycle();
    chk("t6_x5_cleared", operand_a, 32'd0);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      reset     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_dest   = 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      instr     = {$urandom} & 32'hFFFFFF80;
      instr[6:0] = opcs[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) instr = $urandom;
      instr_pc  = $urandom & 32'hFFFFFFFC;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
